// File: rtl/shift_add_pkg.sv
// Shared types for the shift-add multiplier: shift-register control codes
// and the sequencing FSM state encoding.
package shift_add_pkg;

  typedef logic [1:0] sr_ctrl_t;

  localparam sr_ctrl_t SR_HOLD = 2'b00;
  localparam sr_ctrl_t SR_SHR  = 2'b01;
  localparam sr_ctrl_t SR_SHL  = 2'b10;
  localparam sr_ctrl_t SR_LOAD = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/shift_add_ctrl.sv
// Sequencing FSM for the shift-add multiplier: one LOAD, then N iterations of
// TEST -> (ADD) -> SHIFT, then a single-cycle DONE pulse back to IDLE.
module shift_add_ctrl
  import shift_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_lsb,
  output logic [1:0] a_ctrl,
  output logic [1:0] q_ctrl,
  output logic       m_load,
  output logic       acc_clr,
  output logic       add_en,
  output logic       c_clr,
  output logic       busy,
  output logic       done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Outputs depend only on the registered state; start/q_lsb only steer next state.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    a_ctrl    = SR_HOLD;
    q_ctrl    = SR_HOLD;
    m_load    = 1'b0;
    acc_clr   = 1'b0;
    add_en    = 1'b0;
    c_clr     = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        q_ctrl    = SR_LOAD;
        m_load    = 1'b1;
        acc_clr   = 1'b1;
        count_nxt = '0;
        state_nxt = TEST;
      end
      TEST: begin
        state_nxt = q_lsb ? ADD : SHIFT;
      end
      ADD: begin
        add_en    = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        a_ctrl = SR_SHR;
        q_ctrl = SR_SHR;
        c_clr  = 1'b1;
        if (count == LAST) begin
          state_nxt = DONE;
        end else begin
          count_nxt = count + 1'b1;
          state_nxt = TEST;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Bench for shift_add_ctrl: a behavioural A/Q/M/carry datapath closes the loop
// through q_lsb; table-driven multiplies plus reset and handshake sequences.
module tb_shift_add_ctrl;
  import shift_add_pkg::*;

  localparam int N   = 8;
  localparam int WIN = 45;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       q_lsb;
  logic [1:0] a_ctrl, q_ctrl;
  logic       m_load, acc_clr, add_en, c_clr, busy, done;

  logic [N-1:0] mplier = '0;
  logic [N-1:0] mcand  = '0;
  logic [N-1:0] a_reg  = '0;
  logic [N-1:0] q_reg  = '0;
  logic [N-1:0] m_reg  = '0;
  logic         c_reg  = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  shift_add_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .q_lsb  (q_lsb),
    .a_ctrl (a_ctrl),
    .q_ctrl (q_ctrl),
    .m_load (m_load),
    .acc_clr(acc_clr),
    .add_en (add_en),
    .c_clr  (c_clr),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Datapath the controller sequences: A ser_in = carry, Q ser_in = A[0].
  assign q_lsb = q_reg[0];

  always @(posedge clk) begin
    if (m_load) m_reg <= mcand;
    if (q_ctrl == SR_LOAD)     q_reg <= mplier;
    else if (q_ctrl == SR_SHR) q_reg <= {a_reg[0], q_reg[N-1:1]};
    if (acc_clr) begin
      a_reg <= '0;
      c_reg <= 1'b0;
    end else if (add_en) begin
      {c_reg, a_reg} <= {1'b0, a_reg} + {1'b0, m_reg};
    end else if (a_ctrl == SR_SHR) begin
      a_reg <= {c_reg, a_reg[N-1:1]};
    end
    if (c_clr) c_reg <= 1'b0;
  end

  typedef struct {
    logic [7:0]  mp;
    logic [7:0]  mc;
    int          mode;      // 0 single pulse, 1 held high, 2 extra pulses at 5 and 10
    int          exp_done;
    int          exp_ndone;
    int          exp_adds;
    logic [15:0] exp_prod;
    int          exp_load2;
  } vec_t;

  typedef struct {
    int          done_at;
    int          n_done;
    int          adds;
    int          shrs;
    logic [7:0]  add_mask;
    int          load1;
    int          load2;
    int          idle_gap;
    int          viol;
    logic [15:0] prod;
  } obs_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic int out_word();
    return int'({busy, done, a_ctrl, q_ctrl, m_load, acc_clr, add_en, c_clr});
  endfunction

  // Cycle 0 is the IDLE cycle in which start is first high.
  task automatic observe(input int mode, output obs_t o);
    logic prev_add;
    o.done_at = -1; o.n_done = 0; o.adds = 0; o.shrs = 0; o.add_mask = '0;
    o.load1 = -1; o.load2 = -1; o.idle_gap = 0; o.viol = 0; o.prod = '0;
    prev_add = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (a_ctrl == SR_SHL || q_ctrl == SR_SHL) o.viol++;
      if (prev_add && !(a_ctrl == SR_SHR && q_ctrl == SR_SHR)) o.viol++;
      if (m_load) begin
        if (!(acc_clr && q_ctrl == SR_LOAD)) o.viol++;
        if (o.load1 < 0) o.load1 = k;
        else if (o.load2 < 0) o.load2 = k;
      end
      if (o.done_at < 0) begin
        if (!busy) o.viol++;
        if (add_en) begin
          o.adds++;
          if (o.shrs < 8) o.add_mask[o.shrs] = 1'b1;
        end
        if (a_ctrl == SR_SHR) o.shrs++;
      end else if (o.load2 < 0 && !busy) begin
        o.idle_gap++;
      end
      if (done) begin
        o.n_done++;
        if (o.done_at < 0) begin
          o.done_at = k;
          o.prod = {a_reg, q_reg};
        end
      end
      prev_add = add_en;
      case (mode)
        1:       start = (k < 21);
        2:       start = (k == 5 || k == 10);
        default: start = 1'b0;
      endcase
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   found;
    int   nd;

    vecs[0] = '{8'h00, 8'h0D, 0, 18, 1, 0, 16'h0000, -1};
    vecs[1] = '{8'hFF, 8'h0D, 0, 26, 1, 8, 16'h0CF3, -1};
    vecs[2] = '{8'h05, 8'h0D, 0, 20, 1, 2, 16'h0041, -1};
    vecs[3] = '{8'hAA, 8'h11, 0, 22, 1, 4, 16'h0B4A, -1};
    vecs[4] = '{8'h80, 8'hFF, 0, 19, 1, 1, 16'h7F80, -1};
    vecs[5] = '{8'h01, 8'h37, 1, 19, 2, 1, 16'h0037, 21};
    vecs[6] = '{8'h00, 8'h0D, 2, 18, 1, 0, 16'h0000, -1};

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", out_word(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", out_word(), 0);

    // Reset mid-operation, while in SHIFT
    mplier = 8'h00; mcand = 8'h0D;
    start = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_ctrl == SR_SHR) found = 1;
    end
    chk("reach_shift", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_reset_1", out_word(), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midop_reset_2", out_word(), 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("no_done_after_reset", nd, 0);

    // Table-driven multiplies
    for (int i = 0; i < 7; i++) begin
      mplier = vecs[i].mp;
      mcand  = vecs[i].mc;
      observe(vecs[i].mode, o);
      chk($sformatf("v%0d_done_cycle", i), o.done_at, vecs[i].exp_done);
      chk($sformatf("v%0d_done_count", i), o.n_done, vecs[i].exp_ndone);
      chk($sformatf("v%0d_adds", i), o.adds, vecs[i].exp_adds);
      chk($sformatf("v%0d_add_iters", i), int'(o.add_mask), int'(vecs[i].mp));
      chk($sformatf("v%0d_shifts", i), o.shrs, N);
      chk($sformatf("v%0d_load_cycle", i), o.load1, 1);
      chk($sformatf("v%0d_second_load", i), o.load2, vecs[i].exp_load2);
      chk($sformatf("v%0d_product", i), int'(o.prod), int'(vecs[i].exp_prod));
      chk($sformatf("v%0d_violations", i), o.viol, 0);
      if (vecs[i].mode == 1) chk($sformatf("v%0d_idle_gap", i), o.idle_gap, 1);
      chk($sformatf("v%0d_end_idle", i), out_word(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shift_add_ctrl.md
Name: shift_add_ctrl

Overview:
Sequencing FSM for the shift-add multiplier datapath. It drives the 2-bit `ctrl` inputs of the accumulator (A) and multiplier (Q) shift registers, plus the load, clear and add strobes for the multiplicand register, adder and carry flop. It accepts a start/busy/done handshake from the host and issues exactly N add/shift iterations per multiply.

Parameters:
N, 8, operand width in bits; must be >= 2; iteration count = N
CW, $clog2(N), iteration counter width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a multiply; sampled only in IDLE
q_lsb  in  1  Q register bit 0 (Q parallel_out[0])
a_ctrl  out  2  ctrl to A shift register
q_ctrl  out  2  ctrl to Q shift register
m_load  out  1  load multiplicand register
acc_clr  out  1  synchronous clear of A and carry flop
add_en  out  1  latch A+M into A and carry-out into carry flop
c_clr  out  1  clear carry flop
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; product valid in {A,Q}

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- On a `rst`-sampled edge:
  - state = IDLE, count = 0.
  - All outputs 0; a_ctrl and q_ctrl = HOLD (00).
  - Reset mid-operation abandons the multiply; no done pulse is issued.
- Control encoding: HOLD=00, SHR=01, SHL=10, LOAD=11. Only HOLD, SHR and LOAD are used; SHL is never emitted.
- All outputs are Moore, decoded from the registered state; there is no combinational path from start or q_lsb to any output.
- Outputs default to 0/HOLD in every state unless listed below.
- IDLE:
  - busy=0.
  - If start=1, go to LOAD; otherwise stay in IDLE.
- LOAD (1 cycle):
  - q_ctrl=LOAD, m_load=1, acc_clr=1, count<=0.
  - Next state: TEST.
- TEST (1 cycle):
  - Outputs idle.
  - If q_lsb=1, go to ADD; otherwise go to SHIFT.
  - q_lsb is the settled Q bit 0 after the previous LOAD or SHIFT.
- ADD (1 cycle):
  - add_en=1.
  - Next state: SHIFT.
- SHIFT (1 cycle):
  - a_ctrl=SHR, q_ctrl=SHR, c_clr=1.
  - Datapath wiring (not controller logic): A ser_in = carry flop; Q ser_in = A parallel_out[0] (combinational, not the registered ser_out).
  - If count==N-1, go to DONE; otherwise count<=count+1 and go to TEST.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state: IDLE.
- Handshake rules:
  - start while busy=1 is ignored and is not queued.
  - start held high through DONE is accepted again in the IDLE cycle that follows, i.e. back-to-back multiplies have a minimum 1-cycle IDLE gap.
- Latency: let cycle 0 be the IDLE cycle in which start=1.
  - LOAD is cycle 1; iterations start at cycle 2.
  - Each iteration takes 2 cycles, or 3 when the multiplier bit is 1.
  - done is asserted in cycle 2 + 2N + popcount(multiplier).
  - For N=8: done at cycles 18 through 26.
- Counter: CW bits; compared only against N-1, so it never wraps within an operation.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Package shift_add_pkg holds:
  - sr_ctrl_t: 2-bit constants SR_HOLD, SR_SHR, SR_SHL, SR_LOAD, shared with the shift-register instantiations.
  - state_t enum: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- No sub-module: the iteration counter is inline.
- The FSM is one always_ff for state/count plus one always_comb for next-state and output decode.

Test Plan:
- Reset: assert rst for 2 cycles while in SHIFT mid-operation -> next cycle busy=0, done=0, a_ctrl=q_ctrl=00, all strobes 0; no done pulse ever appears.
- N=8, multiplier 0x00: start in cycle 0 -> LOAD strobes in cycle 1; 8 SHR pulses and no add_en; done pulse in cycle 18 only.
- N=8, multiplier 0xFF: 8 add_en pulses, each immediately followed by a SHIFT cycle; done in cycle 26.
- N=8, multiplier 0x05: add_en in iterations 0 and 2 only; done in cycle 20. With the datapath model and multiplicand 0x0D, {A,Q} = 0x0041.
- start held high continuously with multiplier 0x01 -> done at cycle 19; next LOAD at cycle 21, after the IDLE cycle at 20; busy low for exactly 1 cycle between operations.
- start pulsed in cycles 5 and 10 during an active multiply -> ignored; exactly one done per accepted start; iteration count stays 8.
